pi_fix2bcd: RTL and testbench

- Downstream stage of the pi series accumulator.
- Takes the accumulator's unsigned fixed-point result (INT_BITS integer bits, FRAC_BITS fractional bits) and converts it sequentially to 1 integer BCD digit plus NDIGITS fractional BCD digits.
- Uses repeated multiply-by-10, one digit per clock.
- The packed BCD word drives an LCD hex field, so pi shows as readable decimal, e.g. 3141592653589793.

---
 rtl/pi_disp_pkg.sv | 9 +
 rtl/mul10_digit.sv | 12 +
 rtl/pi_fix2bcd.sv | 71 +++++++
 tb/tb_pi_fix2bcd.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pi_disp_pkg.sv
// pi_disp_pkg: shared widths, defaults and FSM states for the pi display path
package pi_disp_pkg;
  localparam int DEF_INT_BITS  = 2;
  localparam int DEF_FRAC_BITS = 48;
  localparam int DEF_NDIGITS   = 15;
  localparam int BCD_W         = 64;
  localparam int CNT_W         = $clog2(DEF_NDIGITS + 1);
  typedef enum logic {IDLE, CONV} state_t;
endpackage

// File: rtl/mul10_digit.sv
// mul10_digit: multiply a binary fraction by ten, splitting off the next decimal digit
module mul10_digit #(
  parameter int FRAC_BITS = 48
) (
  input  logic [FRAC_BITS-1:0] i_f,
  output logic [3:0]           o_digit,
  output logic [FRAC_BITS-1:0] o_f_next
);
  logic [FRAC_BITS+3:0] w_p;
  assign w_p = ({4'b0, i_f} << 3) + ({4'b0, i_f} << 1);
  assign {o_digit, o_f_next} = w_p;
endmodule

// File: rtl/pi_fix2bcd.sv
// pi_fix2bcd: sequential fixed-point to BCD converter, one decimal digit per clock
module pi_fix2bcd
  import pi_disp_pkg::*;
#(
  parameter int INT_BITS  = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int NDIGITS   = DEF_NDIGITS
) (
  input  logic                          clk_2,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] in_value,
  output logic                          busy,
  output logic                          out_valid,
  output logic [BCD_W-1:0]              out_bcd
);
  localparam int CW = $clog2(NDIGITS + 1);
  state_t                   r_state;
  logic [FRAC_BITS-1:0]     r_f;
  logic [FRAC_BITS-1:0]     w_f_next;
  logic [3:0]               w_digit;
  logic [3:0]               w_int;
  logic [3:0]               r_int;
  logic [4*(NDIGITS-1)-1:0] r_digits;
  logic [CW-1:0]            r_cnt;
  logic [BCD_W-1:0]         r_out_bcd;
  logic                     r_out_valid;
  assign w_int     = 4'(in_value[FRAC_BITS +: INT_BITS]);
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state == CONV;
  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  mul10_digit #(.FRAC_BITS(FRAC_BITS)) u_mul10 (
    .i_f      (r_f),
    .o_digit  (w_digit),
    .o_f_next (w_f_next)
  );
  // Accept in IDLE, then shift one digit per clock; the last digit goes straight to the output word
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_f         <= '0;
      r_int       <= '0;
      r_digits    <= '0;
      r_cnt       <= '0;
      r_out_bcd   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (in_valid) begin
          r_int    <= w_int;
          r_digits <= '0;
          r_f      <= in_value[FRAC_BITS-1:0];
          r_cnt    <= '0;
          r_state  <= CONV;
        end
      end else begin
        r_f      <= w_f_next;
        r_cnt    <= r_cnt + 1'b1;
        r_digits <= {r_digits[4*(NDIGITS-2)-1:0], w_digit};
        if (r_cnt == CW'(NDIGITS - 1)) begin
          r_out_bcd   <= {r_int, r_digits, w_digit};
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_pi_fix2bcd.sv
// tb_pi_fix2bcd: randomized self-checking bench against a decimal-expansion reference model
module tb_pi_fix2bcd;
  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [49:0] in_value = '0;
  logic        in_ready, busy, out_valid;
  logic [63:0] out_bcd;
  int errors = 0;
  int checks = 0;

  pi_fix2bcd dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .busy      (busy),
    .out_valid (out_valid),
    .out_bcd   (out_bcd)
  );

  always #5 clk_2 = ~clk_2;

  // Decimal expansion of v/2^48: integer digit, then 15 truncated fractional digits
  function automatic logic [63:0] model(input logic [49:0] v);
    longint unsigned f = 64'(v[47:0]);
    logic [63:0] r = 64'(v[49:48]);
    for (int k = 0; k < 15; k++) begin
      f = f * 10;
      r = (r << 4) | (f >> 48);
      f = f % (64'd1 << 48);
    end
    return r;
  endfunction

  function automatic logic [49:0] rnd50();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[49:0];
  endfunction

  // Present v for one accepting edge, keep junk on in_value (with in_valid high) while busy
  task automatic run(input logic [49:0] v, output logic [63:0] bcd, output int lat, output bit hs_ok);
    hs_ok = 1; lat = -1; bcd = '0;
    @(negedge clk_2); in_valid = 1; in_value = v;
    @(posedge clk_2); #1;
    for (int c = 1; c <= 40; c++) begin
      if (!(in_ready == 1'b0 && busy == 1'b1)) hs_ok = 0;
      in_value = rnd50();
      @(posedge clk_2); #1;
      if (out_valid) begin
        lat = c; bcd = out_bcd;
        if (!(in_ready == 1'b1 && busy == 1'b0)) hs_ok = 0;
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_2);
    #1;
    checks++; if (out_bcd !== 64'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=0", out_bcd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk_2); reset = 0;
  endtask

  task automatic test_vectors();
    logic [49:0] vin [4] = '{50'h3243F6A8885A3, 50'h1800000000000, 50'h0, {50{1'b1}}};
    logic [63:0] vex [4] = '{64'h3141592653589793, 64'h1500000000000000, 64'h0, 64'h3999999999999996};
    logic [63:0] bcd; int lat; bit hs;
    for (int i = 0; i < 4; i++) begin
      run(vin[i], bcd, lat, hs);
      checks++; if (bcd !== vex[i]) begin errors++; $display("FAIL vec%0d_bcd got=%h exp=%h", i, bcd, vex[i]); end
      checks++; if (lat != 15) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=15", i, lat); end
      checks++; if (!hs) begin errors++; $display("FAIL vec%0d_handshake got=0 exp=1", i); end
      @(posedge clk_2); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_pulse got=%b exp=0", i, out_valid); end
      checks++; if (out_bcd !== vex[i]) begin errors++; $display("FAIL vec%0d_hold got=%h exp=%h", i, out_bcd, vex[i]); end
    end
  endtask

  task automatic test_random();
    logic [49:0] v; logic [63:0] bcd; int lat; bit hs;
    for (int i = 0; i < 20; i++) begin
      v = rnd50();
      run(v, bcd, lat, hs);
      checks++; if (bcd !== model(v)) begin errors++; $display("FAIL rand%0d_bcd in=%h got=%h exp=%h", i, v, bcd, model(v)); end
      checks++; if (lat != 15 || !hs) begin errors++; $display("FAIL rand%0d_timing lat=%0d hs=%0b exp lat=15 hs=1", i, lat, hs); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] held;
    int last = 0, n_acc = 0;
    bit spacing_ok = 1, hold_ok = 1, hs_ok = 1;
    held = out_bcd;
    in_valid = 1;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk_2);
      in_value = rnd50();
      if (in_ready === busy) hs_ok = 0;
      if (in_ready) begin
        q.push_back(model(in_value));
        if (n_acc > 0 && c - last != 16) spacing_ok = 0;
        last = c; n_acc++;
      end
      @(posedge clk_2); #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || out_bcd !== q[0]) begin
          errors++; $display("FAIL b2b_bcd got=%h exp=%h", out_bcd, (q.size() != 0) ? q[0] : 64'hx);
        end
        if (q.size() != 0) void'(q.pop_front());
        held = out_bcd;
      end else if (out_bcd !== held) hold_ok = 0;
    end
    in_valid = 0;
    checks++; if (n_acc != 6) begin errors++; $display("FAIL b2b_accepts got=%0d exp=6", n_acc); end
    checks++; if (!spacing_ok) begin errors++; $display("FAIL b2b_spacing got=irregular exp=16"); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d exp=0", q.size()); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL b2b_hold got=changed exp=stable"); end
    checks++; if (!hs_ok) begin errors++; $display("FAIL b2b_ready_busy got=equal exp=complementary"); end
  endtask

  task automatic test_reset_mid();
    logic [49:0] v; logic [63:0] bcd; int lat; bit hs; bit pulse = 0;
    @(negedge clk_2); in_valid = 1; in_value = rnd50();
    @(posedge clk_2); #1 in_valid = 0;
    repeat (7) @(posedge clk_2);
    #2 reset = 1;
    #1;
    checks++; if (out_bcd !== 64'h0) begin errors++; $display("FAIL mid_reset_bcd got=%h exp=0", out_bcd); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_state ready=%b busy=%b exp 1 0", in_ready, busy); end
    @(negedge clk_2); reset = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_2); #1;
      if (out_valid !== 1'b0 || out_bcd !== 64'h0) pulse = 1;
    end
    checks++; if (pulse) begin errors++; $display("FAIL mid_reset_quiet got=pulse exp=none"); end
    v = rnd50();
    run(v, bcd, lat, hs);
    checks++; if (bcd !== model(v) || lat != 15) begin errors++; $display("FAIL mid_reset_next got=%h lat=%0d exp=%h lat=15", bcd, lat, model(v)); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
